servo_pwm_scheduler: RTL and testbench

Multi-channel servo PWM scheduler. Owns a shared microsecond timebase (clock prescaler plus 20 ms frame counter) and generates one PWM output per servo channel from it. Per-channel pulse widths arrive from the SPI command decoder over a valid/ready handshake. Updates are double-buffered and applied only at frame boundaries, so every output pulse is glitch-free.

---
 rtl/servo_pwm_scheduler.sv | 113 +++++++++++
 tb/tb_servo_pwm_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_scheduler.sv
// Multi-channel servo PWM scheduler with a shared tick/frame timebase and double-buffered widths.
// Optional feature: define SERVO_SLEW_EN to rate-limit active width changes per frame.
module servo_pwm_scheduler #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned CENTER_US = 1500,
    parameter int unsigned SLEW_STEP = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_ch,
    input  logic [14:0]    cmd_width,
    output logic [NCH-1:0] pwm,
    output logic           frame_start,
    output logic           cmd_err
);

    localparam int unsigned WW = 15;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (NCH == 0 || NCH > 8 || TICK_DIV == 0 || PERIOD_US > 32768 || MIN_US > MAX_US ||
        MAX_US >= PERIOD_US || CENTER_US > MAX_US || SLEW_STEP == 0) begin : g_bad_cfg
        $error("servo_pwm_scheduler: unsupported parameter set");
    end

    logic [PW-1:0] pre;
    logic [WW-1:0] cnt;
    logic [WW-1:0] shadow [NCH];
    logic [WW-1:0] active [NCH];
    logic          rst_q;
    logic          tick;
    logic          fb;
    logic          accept;
    logic          ch_ok;
    logic [WW-1:0] width_c;

    function automatic logic [WW-1:0] clamp_width(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = w;
        if (w == '0)
            r = '0;
        else if (w < WW'(MIN_US))
            r = WW'(MIN_US);
        else if (w > WW'(MAX_US))
            r = WW'(MAX_US);
        return r;
    endfunction

`ifdef SERVO_SLEW_EN
    // Enable/disable transitions bypass the rate limit.
    function automatic logic [WW-1:0] next_width(input logic [WW-1:0] cur, input logic [WW-1:0] tgt);
        logic [WW-1:0] r;
        r = tgt;
        if (cur != '0 && tgt != '0) begin
            if (tgt > cur && (tgt - cur) > WW'(SLEW_STEP))
                r = cur + WW'(SLEW_STEP);
            else if (cur > tgt && (cur - tgt) > WW'(SLEW_STEP))
                r = cur - WW'(SLEW_STEP);
        end
        return r;
    endfunction
`else
    function automatic logic [WW-1:0] next_width(input logic [WW-1:0] cur, input logic [WW-1:0] tgt);
        logic [WW-1:0] unused_cur;
        unused_cur = cur;
        return tgt;
    endfunction
`endif

    // rst_q marks the first cycle out of reset: timebase holds at zero and the frame is announced.
    assign tick      = !rst && !rst_q && (pre == PW'(TICK_DIV - 1));
    assign fb        = tick && (cnt == WW'(PERIOD_US - 1));
    assign cmd_ready = !rst && !fb;
    assign accept    = cmd_valid && cmd_ready;
    assign ch_ok     = {1'b0, cmd_ch} < 4'(NCH);
    assign width_c   = clamp_width(cmd_width);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            cnt         <= '0;
            rst_q       <= 1'b1;
            frame_start <= 1'b0;
            cmd_err     <= 1'b0;
            pwm         <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= WW'(CENTER_US);
                active[i] <= WW'(CENTER_US);
            end
        end else begin
            rst_q       <= 1'b0;
            frame_start <= rst_q || fb;
            cmd_err     <= accept && !ch_ok;
            if (!rst_q)
                pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                cnt <= fb ? '0 : cnt + 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (accept && ch_ok && cmd_ch == 3'(i))
                    shadow[i] <= width_c;
                if (fb)
                    active[i] <= next_width(active[i], shadow[i]);
                pwm[i] <= !rst_q && (active[i] != '0) && (cnt < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Scoreboard bench for servo_pwm_scheduler: frame-level reference model feeds per-frame width expectations.
module tb_servo_pwm_scheduler;

    localparam int NCH       = 4;
    localparam int TICK_DIV  = 3;
    localparam int PERIOD_US = 60;
    localparam int MIN_US    = 10;
    localparam int MAX_US    = 40;
    localparam int CENTER_US = 25;
`ifdef SERVO_SLEW_EN
    localparam int SLEW_STEP = 4;
`endif
    localparam int FL        = TICK_DIV * PERIOD_US;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [2:0]     cmd_ch = '0;
    logic [14:0]    cmd_width = '0;
    logic           cmd_ready;
    logic [NCH-1:0] pwm;
    logic           frame_start;
    logic           cmd_err;

    servo_pwm_scheduler #(
        .NCH(NCH), .TICK_DIV(TICK_DIV), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .CENTER_US(CENTER_US)
`ifdef SERVO_SLEW_EN
        , .SLEW_STEP(SLEW_STEP)
`endif
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_width(cmd_width), .pwm(pwm),
        .frame_start(frame_start), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    int expq[$];
    int errq[$];
    int shadow_m[NCH];
    int active_m[NCH];
    bit started = 1'b0;
    int t0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_m(input int w);
        if (w == 0) return 0;
        if (w < MIN_US) return MIN_US;
        if (w > MAX_US) return MAX_US;
        return w;
    endfunction

    function automatic int step_m(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
        if (cur != 0 && tgt != 0) begin
            if (tgt > cur + SLEW_STEP) return cur + SLEW_STEP;
            if (tgt < cur - SLEW_STEP) return cur - SLEW_STEP;
        end
`else
        if (cur < 0) return tgt;
`endif
        return tgt;
    endfunction

    function automatic bit model_fs();
        return started && cyc >= t0 && ((cyc - t0) % FL) == 0;
    endfunction

    function automatic bit model_ready();
        return !rst && !(started && cyc >= t0 && ((cyc - t0 + 1) % FL) == 0);
    endfunction

    function automatic int rand_width();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return int'($urandom_range(1, MIN_US - 1));
            2:       return int'($urandom_range(MIN_US, MAX_US));
            3:       return int'($urandom_range(MAX_US + 1, 32767));
            4:       return MIN_US;
            default: return MAX_US;
        endcase
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            shadow_m[c] = CENTER_US;
            active_m[c] = CENTER_US;
        end
    endtask

    // Advance to the next sampling point, roll the model's frame and check the per-cycle outputs.
    task automatic tick_cycle();
        bit r;
        r = rst;
        @(negedge clk);
        if (model_fs()) begin
            if (cyc > t0)
                for (int c = 0; c < NCH; c++) active_m[c] = step_m(active_m[c], shadow_m[c]);
            for (int c = 0; c < NCH; c++) expq.push_back(active_m[c]);
        end
        check("cmd_ready", cmd_ready, model_ready());
        check("frame_start", frame_start, model_fs());
        if (r) begin
            check("rst_pwm", pwm, 0);
            check("rst_cmd_err", cmd_err, 0);
        end
    endtask

    task automatic wait_to(input int frame, input int off);
        while (cyc < t0 + frame * FL + off) tick_cycle();
    endtask

    task automatic send(input int ch, input int w);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_ch    = 3'(ch);
        cmd_width = 15'(w);
        for (int i = 0; i < 4 && !done; i++) begin
            if (model_ready()) begin
                done = 1'b1;
                if (ch < NCH) shadow_m[ch] = clamp_m(w);
                else errq.push_back(cyc + 1);
            end
            tick_cycle();
        end
        cmd_valid = 1'b0;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: command ch %0d never accepted (cycle %0d)", ch, cyc);
        end
    endtask

    task automatic random_until(input int stop);
        while (cyc < stop) begin
            if ($urandom_range(0, 7) == 0) send(int'($urandom_range(0, 7)), rand_width());
            else tick_cycle();
        end
    endtask

    // Monitor: measures each completed DUT frame and compares against the queued expectation.
    initial begin
        int  hi[NCH];
        int  first[NCH];
        int  pos;
        bit  inf;
        bit  exp_err;
        int  e;
        inf = 1'b0;
        pos = 0;
        forever begin
            @(negedge clk);
            exp_err = errq.size() > 0 && errq[0] == cyc;
            check("cmd_err", cmd_err, exp_err);
            while (errq.size() > 0 && errq[0] <= cyc) void'(errq.pop_front());
            if (rst) begin
                inf = 1'b0;
            end else begin
                if (frame_start === 1'b1) begin
                    if (inf) begin
                        if (expq.size() < NCH) begin
                            check("exp_available", expq.size(), NCH);
                        end else begin
                            for (int c = 0; c < NCH; c++) begin
                                e = expq.pop_front();
                                check($sformatf("pwm%0d_high_cycles", c), hi[c], e * TICK_DIV);
                                check($sformatf("pwm%0d_first_high", c), first[c], (e == 0) ? -1 : 1);
                            end
                        end
                    end
                    inf = 1'b1;
                    pos = 0;
                    hi = '{default: 0};
                    first = '{default: -1};
                end
                if (inf) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (pwm[c] === 1'b1) begin
                            hi[c]++;
                            if (first[c] < 0) first[c] = pos;
                        end
                    end
                    pos++;
                end
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        reset_model();
        repeat (4) tick_cycle();
        rst = 1'b0;
        t0 = cyc + 1;
        started = 1'b1;

        wait_to(1, 50);
        send(1, 35);
        wait_to(2, 20);
        send(0, 5);
        send(0, 50);
        send(2, 0);
        wait_to(2, FL - 1);
        send(3, 30);
        send(5, 20);
        send(7, 0);

        random_until(t0 + 8 * FL - 30);
        wait_to(8, 10);
        for (int c = 0; c < NCH; c++) send(c, 30);

        wait_to(9, 5 * TICK_DIV + 1);
        check("pwm_before_reset", pwm, (1 << NCH) - 1);
        rst = 1'b1;
        started = 1'b0;
        expq.delete();
        reset_model();
        cmd_valid = 1'b1;
        cmd_ch    = 3'd0;
        cmd_width = 15'(MAX_US);
        repeat (3) tick_cycle();
        cmd_valid = 1'b0;
        rst = 1'b0;
        t0 = cyc + 1;
        started = 1'b1;

        wait_to(0, 30);
        random_until(t0 + 3 * FL + FL / 2);
        repeat (3) tick_cycle();
        check("open_frame_expectations", expq.size(), NCH);
        check("pending_cmd_err", errq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
